// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared constants and types for the serial shift link
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Shift direction encoding, shared with the transmit-side shift register
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - 0..WIDTH-1 bit counter for one serial frame
module frame_bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last_o = (count_q == CW'(WIDTH - 1));

  // A clear coinciding with an increment restarts the count at the new first bit
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = inc_i ? CW'(1) : '0;
    end else if (inc_i) begin
      count_d = last_o ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel receiver with double-buffered word output
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             bit_valid,
  input  logic             dir,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             busy
);

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             cnt_last;
  logic             frame_start;
  logic             shift_dir;
  logic [WIDTH-1:0] shift_base;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             load_word;
  logic             drop_word;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sh,
                                                input logic             b,
                                                input logic             d);
    return (d == DIR_LEFT) ? {sh[WIDTH-2:0], b} : {b, sh[WIDTH-1:1]};
  endfunction

  frame_bit_counter #(
    .WIDTH(WIDTH)
  ) u_frame_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .clear_i(sync),
    .inc_i  (bit_valid),
    .last_o (cnt_last)
  );

  // A sync turns the coincident bit into the first bit of a fresh frame
  assign frame_start = sync || (state_q == IDLE);
  assign shift_dir   = frame_start ? dir : dir_q;
  assign shift_base  = frame_start ? '0 : sh_q;
  assign shifted     = shift_in(shift_base, ser_in, shift_dir);
  assign complete    = bit_valid && !sync && (state_q == COLLECT) && cnt_last;
  assign load_word   = complete && (!valid_q || out_ready);
  assign drop_word   = complete && valid_q && !out_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dir_d   = dir_q;
    if (sync) begin
      state_d = IDLE;
      sh_d    = '0;
    end
    if (bit_valid) begin
      sh_d    = shifted;
      state_d = complete ? IDLE : COLLECT;
      if (frame_start) begin
        dir_d = dir;
      end
    end
  end

  // Output buffer: a word accepted this cycle frees the slot for a completing frame
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load_word) begin
      data_d  = shifted;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    ovr_d = ovr_q;
    if (drop_word) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dir_q   <= DIR_LEFT;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == COLLECT);

endmodule
